pc_flag_ctrl: RTL

- Sequential program-counter and condition-flag stage that sits directly downstream of the ALU (addsub_16bit / shifter result path).
- Captures Z/N/V flags from each ALU result and evaluates branch conditions against them.
- Holds and advances the 16-bit PC, and latches the HALT state.
- Feeds the instruction-fetch address each cycle.

---
 rtl/pc_flag_ctrl_if.sv | 30 +++
 rtl/pc_flag_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pc_flag_ctrl_if.sv
// Signal bundle between the ALU/decode stage (master) and the PC/flag stage (slave).
interface pc_flag_ctrl_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 3;

    logic              stall;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovfl;
    logic [1:0]        flag_upd;
    logic [1:0]        br_type;
    logic [2:0]        cond;
    logic [8:0]        imm9;
    logic [DATA_W-1:0] br_reg;
    logic              halt;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus2;
    logic              taken;
    logic [FLAG_W-1:0] flags;
    logic              halted;

    modport master (
        output stall, alu_result, alu_ovfl, flag_upd, br_type, cond, imm9, br_reg, halt,
        input  pc, pc_plus2, taken, flags, halted
    );

    modport slave (
        input  stall, alu_result, alu_ovfl, flag_upd, br_type, cond, imm9, br_reg, halt,
        output pc, pc_plus2, taken, flags, halted
    );
endinterface

// File: rtl/pc_flag_ctrl.sv
// PC / condition-flag stage: captures Z/N/V, resolves branches, advances PC, latches HALT.
// Optional macro FLAG_BYPASS_EN: branch conditions see the flags being written this cycle.
module pc_flag_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_INC   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_flag_ctrl_if.slave bus
);
    localparam int unsigned PC_W   = 16;
    localparam int unsigned FLAG_W = 3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_flags_nxt;
    logic [FLAG_W-1:0] w_flags_wr;
    logic [FLAG_W-1:0] w_flags_eval;
    logic [PC_W-1:0]   w_pc_plus2;
    logic [PC_W-1:0]   w_br_off;
    logic [PC_W-1:0]   w_br_target;
    logic              w_is_br;
    logic              w_cond_true;
    logic              w_taken;
    logic              w_z;
    logic              w_n;
    logic              w_v;

    assign w_pc_plus2 = r_pc + PC_W'(PC_INC);
    // imm9 counts instructions; scale to bytes after sign extension
    assign w_br_off    = {{6{bus.imm9[8]}}, bus.imm9, 1'b0};
    assign w_br_target = (bus.br_type == 2'b10) ? bus.br_reg : (w_pc_plus2 + w_br_off);
    assign w_is_br     = (bus.br_type == 2'b01) || (bus.br_type == 2'b10);

    // Flag value this instruction would write; reserved code leaves flags alone
    always_comb begin
        w_flags_wr = r_flags;
        case (bus.flag_upd)
            2'b01:   w_flags_wr[2] = (bus.alu_result == '0);
            2'b10:   w_flags_wr    = {(bus.alu_result == '0), bus.alu_result[PC_W-1], bus.alu_ovfl};
            default: w_flags_wr    = r_flags;
        endcase
    end

`ifdef FLAG_BYPASS_EN
    assign w_flags_eval = w_flags_wr;
`else
    assign w_flags_eval = r_flags;
`endif

    assign w_z = w_flags_eval[2];
    assign w_n = w_flags_eval[1];
    assign w_v = w_flags_eval[0];

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond)
            3'b000:  w_cond_true = ~w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = ~w_z & ~w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z | (~w_z & ~w_n);
            3'b101:  w_cond_true = w_n | w_z;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_taken = w_is_br & w_cond_true & (r_state == ST_RUN);

    // Next-state: halt wins over branch for the PC, but flags still update
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
        if (!bus.stall && (r_state == ST_RUN)) begin
            w_flags_nxt = w_flags_wr;
            if (bus.halt) begin
                w_state_nxt = ST_HALT;
            end else begin
                w_pc_nxt = w_taken ? w_br_target : w_pc_plus2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus2 = w_pc_plus2;
    assign bus.taken    = w_taken;
    assign bus.flags    = r_flags;
    assign bus.halted   = (r_state == ST_HALT);
endmodule
